// File: rtl/lif_layer.sv
// lif_layer: a layer of integrate-and-fire neurons fed by a binary input
// spike vector, processed one timestep per step_valid/step_ready handshake.
// Weights sit in an address-decoded register array (neuron in addr[27:8],
// input index in addr[7:0]) and are never touched by reset.
// Optional feature macro: LIF_LAYER_LEAK_EN enables a per-timestep leak of
// LEAK toward RESET for neurons that do not fire; without it the neurons
// are pure integrate-and-fire and LEAK has no effect.
//
// state | meaning
// IDLE  | waiting for a timestep; weight writes accepted
// ACCUM | one input index per cycle, adding weights of active inputs
// FIRE  | threshold compare: spike/reset/refractory load, or leak/decrement
// DONE  | publish spike vector and pulse spike_out_valid
module lif_layer #(
  parameter longint      THRESH      = 15,
  parameter longint      RESET       = 0,
  parameter int unsigned REFRAC      = 5,
  parameter int unsigned LEAK        = 1,
  parameter int          WEIGHT_SIZE = 32,
  parameter int          NUM_INPUTS  = 4,
  parameter int          NUM_NEURONS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [NUM_INPUTS-1:0]  spike_in,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   spike_out_valid,
  input  logic [27:0]            mem_addr,
  input  logic [WEIGHT_SIZE-1:0] mem_din,
  input  logic                   mem_wen,
  output logic [WEIGHT_SIZE-1:0] mem_dout
);

  localparam int PW = WEIGHT_SIZE + 8;
  localparam int JW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [PW-1:0] THRESH_P = PW'(THRESH);
  localparam logic signed [PW-1:0] RESET_P  = PW'(RESET);
  localparam logic signed [PW-1:0] POT_MAX  = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] POT_MIN  = {1'b1, {(PW-1){1'b0}}};
  localparam logic [RW-1:0]        REFRAC_P = RW'(REFRAC);
  localparam logic [JW-1:0]        LAST_J   = JW'(NUM_INPUTS - 1);

`ifdef LIF_LAYER_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif
  // A zero leak amount leaves the potential untouched in FIRE.
  localparam logic signed [PW:0] LEAK_AMT = LEAK_ON ? (PW+1)'(LEAK) : '0;

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [JW-1:0]          j;
  logic [NUM_INPUTS-1:0]  spikes_lat;
  logic [NUM_NEURONS-1:0] fire_vec, fire_nxt;
  logic                   accept, do_accum, do_fire, do_done;

  logic [WEIGHT_SIZE-1:0] weight    [NUM_NEURONS][NUM_INPUTS];
  logic signed [PW-1:0]   potential [NUM_NEURONS];
  logic signed [PW-1:0]   pot_nxt   [NUM_NEURONS];
  logic [RW-1:0]          refrac    [NUM_NEURONS];
  logic [RW-1:0]          ref_nxt   [NUM_NEURONS];

  logic [19:0]            addr_n;
  logic [7:0]             addr_i;
  logic                   addr_ok;
  logic [NW-1:0]          sel_n;
  logic [JW-1:0]          sel_i;

  // Add with clamping at the potential's signed range instead of wrapping.
  function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] p,
                                                   input logic signed [WEIGHT_SIZE-1:0] w);
    logic signed [PW:0] s;
    s = (PW+1)'(p) + (PW+1)'(w);
    if (s[PW] != s[PW-1]) sat_add = s[PW] ? POT_MIN : POT_MAX;
    else                  sat_add = s[PW-1:0];
  endfunction

  // Move toward RESET by LEAK_AMT, landing exactly on RESET rather than crossing it.
  function automatic logic signed [PW-1:0] leak_step(input logic signed [PW-1:0] p);
    logic signed [PW:0] pe, d;
    pe = (PW+1)'(p);
    d  = pe - (PW+1)'(RESET_P);
    if (d > LEAK_AMT)       leak_step = PW'(pe - LEAK_AMT);
    else if (d < -LEAK_AMT) leak_step = PW'(pe + LEAK_AMT);
    else                    leak_step = RESET_P;
  endfunction

  assign addr_n  = mem_addr[27:8];
  assign addr_i  = mem_addr[7:0];
  assign addr_ok = (32'(addr_n) < NUM_NEURONS) && (32'(addr_i) < NUM_INPUTS);
  assign sel_n   = addr_n[NW-1:0];
  assign sel_i   = addr_i[JW-1:0];
  assign accept  = step_valid && step_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (j == LAST_J) state_nxt = FIRE;
      FIRE:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake plus per-state datapath enables
  always_comb begin
    step_ready = (state == IDLE) && !rst;
    do_accum   = (state == ACCUM);
    do_fire    = (state == FIRE);
    do_done    = (state == DONE);
  end

  // capture the offered timestep and walk the input index through ACCUM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spikes_lat <= '0;
      j          <= '0;
    end else if (accept) begin
      spikes_lat <= spike_in;
      j          <= '0;
    end else if (do_accum) begin
      j <= j + JW'(1);
    end
  end

  // per-neuron integrate, fire/reset/refractory, or leak/countdown
  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      pot_nxt[n]  = potential[n];
      ref_nxt[n]  = refrac[n];
      fire_nxt[n] = (refrac[n] == '0) && (potential[n] >= THRESH_P);
      if (do_accum) begin
        if (spikes_lat[j] && (refrac[n] == '0))
          pot_nxt[n] = sat_add(potential[n], weight[n][j]);
      end else if (do_fire) begin
        if (fire_nxt[n]) begin
          pot_nxt[n] = RESET_P;
          ref_nxt[n] = REFRAC_P;
        end else begin
          pot_nxt[n] = leak_step(potential[n]);
          if (refrac[n] != '0) ref_nxt[n] = refrac[n] - RW'(1);
        end
      end
    end
  end

  // neuron state registers; the weight array is kept out of reset on purpose
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        potential[n] <= RESET_P;
        refrac[n]    <= '0;
      end
      fire_vec <= '0;
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        potential[n] <= pot_nxt[n];
        refrac[n]    <= ref_nxt[n];
      end
      if (do_fire) fire_vec <= fire_nxt;
    end
  end

  // publish the spike vector once per timestep and hold it until the next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_out       <= '0;
      spike_out_valid <= 1'b0;
    end else begin
      spike_out_valid <= do_done;
      if (do_done) spike_out <= fire_vec;
    end
  end

  // weight writes only while idle and in range; a write on the accepting edge still lands
  always_ff @(posedge clk) begin
    if (mem_wen && (state == IDLE) && addr_ok)
      weight[sel_n][sel_i] <= mem_din;
  end

  // registered read port, usable in any state; out-of-range reads return zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mem_dout <= '0;
    else if (addr_ok) mem_dout <= weight[sel_n][sel_i];
    else              mem_dout <= '0;
  end

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer: a 4-input/2-neuron layer for the main
// behaviour and a 1-neuron layer with a maximal threshold for saturation.
// Expected potentials follow LIF_LAYER_LEAK_EN when it is defined.
module tb_lif_layer;

`ifdef LIF_LAYER_LEAK_EN
  localparam logic [63:0] EXP_P1    = 64'd6;
  localparam logic [63:0] EXP_P2    = 64'd12;
  localparam logic [63:0] EXP_POT64 = 64'd549755813568;
`else
  localparam logic [63:0] EXP_P1    = 64'd7;
  localparam logic [63:0] EXP_P2    = 64'd14;
  localparam logic [63:0] EXP_POT64 = 64'd549755813632;
`endif

  logic        clk;
  logic        rst;
  logic        step_valid;
  logic        step_ready;
  logic [3:0]  spike_in;
  logic [1:0]  spike_out;
  logic        spike_out_valid;
  logic [27:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wen;
  logic [31:0] mem_dout;

  logic        s_rst;
  logic        s_step_valid;
  logic        s_step_ready;
  logic [3:0]  s_spike_in;
  logic [0:0]  s_spike_out;
  logic        s_spike_out_valid;
  logic [27:0] s_mem_addr;
  logic [31:0] s_mem_din;
  logic        s_mem_wen;
  logic [31:0] s_mem_dout;

  int n_checks;
  int n_fail;

  lif_layer #(
    .THRESH(15), .RESET(0), .REFRAC(5), .LEAK(1),
    .WEIGHT_SIZE(32), .NUM_INPUTS(4), .NUM_NEURONS(2)
  ) u_dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(step_ready),
    .spike_in(spike_in), .spike_out(spike_out), .spike_out_valid(spike_out_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout)
  );

  lif_layer #(
    .THRESH(64'sd549755813887), .RESET(0), .REFRAC(5), .LEAK(1),
    .WEIGHT_SIZE(32), .NUM_INPUTS(4), .NUM_NEURONS(1)
  ) u_sat (
    .clk(clk), .rst(s_rst), .step_valid(s_step_valid), .step_ready(s_step_ready),
    .spike_in(s_spike_in), .spike_out(s_spike_out), .spike_out_valid(s_spike_out_valid),
    .mem_addr(s_mem_addr), .mem_din(s_mem_din), .mem_wen(s_mem_wen), .mem_dout(s_mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [27:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr = a;
    mem_din  = d;
    mem_wen  = 1'b1;
    @(negedge clk);
    mem_wen  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [27:0] a, input logic [31:0] exp);
    @(negedge clk);
    mem_addr = a;
    @(negedge clk);
    check(tag, 64'(mem_dout), 64'(exp));
  endtask

  // One timestep: optional write on the accepting edge, optional write on the first ACCUM edge.
  task automatic run_step(input string tag, input logic [3:0] sp, input logic [1:0] exp_sp,
                          input logic acc_wen, input logic mid_wen,
                          input logic [27:0] waddr, input logic [31:0] wdata);
    int edges;
    @(negedge clk);
    step_valid = 1'b1;
    spike_in   = sp;
    mem_addr   = waddr;
    mem_din    = wdata;
    mem_wen    = acc_wen;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    spike_in   = '0;
    mem_wen    = mid_wen;
    edges = 0;
    while (spike_out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      mem_wen = 1'b0;
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd6);
    check({tag, "_spikes"}, 64'(spike_out), 64'(exp_sp));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(spike_out_valid), 64'd0);
  endtask

  initial begin
    int          first_fire;
    int          edges;
    logic        saw_valid;
    logic [39:0] pot64;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; step_valid = 1'b0; spike_in = '0;
    mem_addr = '0; mem_din = '0; mem_wen = 1'b0;
    s_rst = 1'b1; s_step_valid = 1'b0; s_spike_in = '0;
    s_mem_addr = '0; s_mem_din = '0; s_mem_wen = 1'b0;
    pot64 = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", 64'(step_ready), 64'd0);
    check("rst_valid", 64'(spike_out_valid), 64'd0);
    check("rst_spikes", 64'(spike_out), 64'd0);
    check("rst_dout", 64'(mem_dout), 64'd0);
    rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(step_ready), 64'd1);
    check("sat_ready_after_rst", 64'(s_step_ready), 64'd1);

    // weights: neuron0 = {8,8,0,0}, neuron1 = all zero
    wr(28'h000, 32'd8);
    wr(28'h001, 32'd8);
    wr(28'h002, 32'd0);
    wr(28'h003, 32'd0);
    for (int i = 0; i < 4; i++) wr(28'h100 + 28'(i), 32'd0);
    rd("rd_w00", 28'h000, 32'd8);
    rd("rd_w01", 28'h001, 32'd8);

    // out-of-range writes must not alias onto weight[0][0]
    wr(28'h004, 32'd99);
    wr(28'h200, 32'd99);
    wr(28'h0010000, 32'd99);
    rd("no_alias_w00", 28'h000, 32'd8);
    rd("oob_index_rd", 28'h004, 32'd0);
    rd("oob_neuron_rd", 28'h200, 32'd0);

    // 8+8 = 16 >= 15: neuron0 fires, potential back to RESET
    run_step("fire1", 4'b0011, 2'b01, 1'b0, 1'b0, 28'h000, 32'd0);
    check("fire1_pot", 64'(u_dut.potential[0]), 64'd0);
    repeat (3) @(negedge clk);
    check("hold_spikes", 64'(spike_out), 64'd1);

    // five refractory timesteps, then the sixth fires; a write during ACCUM is dropped
    for (int r = 0; r < 5; r++)
      run_step("refrac", 4'b0011, 2'b00, 1'b0, 1'b0, 28'h000, 32'd0);
    run_step("refire", 4'b0011, 2'b01, 1'b0, 1'b1, 28'h003, 32'd50);
    rd("busy_write_dropped", 28'h003, 32'd0);

    // reset in the middle of ACCUM abandons the step
    @(negedge clk);
    mem_addr   = 28'h000;
    step_valid = 1'b1;
    spike_in   = 4'b0011;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    spike_in   = '0;
    @(posedge clk);
    #1;
    check("pre_rst_dout", 64'(mem_dout), 64'd8);
    check("pre_rst_spikes", 64'(spike_out), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(step_ready), 64'd0);
    check("mid_rst_valid", 64'(spike_out_valid), 64'd0);
    check("mid_rst_spikes", 64'(spike_out), 64'd0);
    check("mid_rst_dout", 64'(mem_dout), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (spike_out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("abandon_no_valid", 64'(saw_valid), 64'd0);
    check("abandon_ready", 64'(step_ready), 64'd1);
    check("abandon_pot", 64'(u_dut.potential[0]), 64'd0);
    rd("kept_w00", 28'h000, 32'd8);
    rd("kept_w01", 28'h001, 32'd8);

    // weight 7 written on the accepting edge is used by that very step
    run_step("leak1", 4'b0001, 2'b00, 1'b1, 1'b0, 28'h000, 32'd7);
    check("leak1_pot", 64'(u_dut.potential[0]), EXP_P1);
    run_step("leak2", 4'b0001, 2'b00, 1'b0, 1'b0, 28'h000, 32'd0);
    check("leak2_pot", 64'(u_dut.potential[0]), EXP_P2);
    rd("acc_write_w00", 28'h000, 32'd7);

    // saturation: 0x7FFFFFFF on all four inputs until the clamp reaches the threshold
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_mem_addr = 28'(i);
      s_mem_din  = 32'h7FFF_FFFF;
      s_mem_wen  = 1'b1;
    end
    @(negedge clk);
    s_mem_wen  = 1'b0;
    s_mem_addr = 28'h003;
    @(negedge clk);
    check("sat_rd_w03", 64'(s_mem_dout), 64'h7FFF_FFFF);

    first_fire = 0;
    for (int k = 1; k <= 70 && first_fire == 0; k++) begin
      @(negedge clk);
      s_step_valid = 1'b1;
      s_spike_in   = 4'b1111;
      @(posedge clk);
      #1;
      s_step_valid = 1'b0;
      s_spike_in   = '0;
      edges = 0;
      while (s_spike_out_valid !== 1'b1 && edges < 20) begin
        @(posedge clk);
        #1;
        edges++;
      end
      if (s_spike_out[0] === 1'b1) first_fire = k;
      if (k == 64) pot64 = u_sat.potential[0];
    end
    check("sat_pot_step64", 64'(pot64), EXP_POT64);
    check("sat_first_fire", 64'(first_fire), 64'd65);
    check("sat_pot_after_fire", 64'(u_sat.potential[0]), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
